// File: rtl/sram_slot_pkg.sv
// rtl/sram_slot_pkg.sv - slot length, slot phase constants and CPU FSM encoding
// Shared by slot_timer and sram_slot_arbiter; VIDEO_STEAL_EN is handled in slot_timer.
package sram_slot_pkg;

  localparam int SLOT_LEN = 4;

  localparam logic [1:0] PH_ADDR   = 2'd0;
  localparam logic [1:0] PH_STROBE = 2'd1;
  localparam logic [1:0] PH_DATA   = 2'd2;
  localparam logic [1:0] PH_ACK    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_DATA,
    ST_ACK
  } cpu_state_e;

endpackage

// File: rtl/sram_slot_arbiter_timer.sv
// rtl/sram_slot_arbiter_timer.sv - clk24 slot counter with ce12/ce6/video_slice/pipe_ab decode
// VIDEO_STEAL_EN: a video slot whose phase-0 vid_blank is 1 becomes a CPU slot.
module slot_timer
  import sram_slot_pkg::*;
(
  input  logic       clk24,
  input  logic       reset,
  input  logic       vid_blank,
  output logic [1:0] phase,
  output logic       ce12,
  output logic       ce6,
  output logic       video_slice,
  output logic       pipe_ab,
  output logic       cpu_slot
);

  logic [4:0] sc_q, sc_d;
  logic       pipe_q, pipe_d;
  logic       steal_q, steal_d;

  always_comb begin
    sc_d   = sc_q + 5'd1;
    pipe_d = sc_q[2] ? pipe_q : sc_q[3];
`ifdef VIDEO_STEAL_EN
    // Decision is taken live at phase 0 and frozen for the rest of the slot.
    steal_d = (sc_q[1:0] == PH_ADDR) ? (~sc_q[2] & vid_blank) : steal_q;
`else
    steal_d = 1'b0;
`endif
  end

`ifndef VIDEO_STEAL_EN
  logic unused_ok;
  assign unused_ok = vid_blank ^ steal_q;
`endif

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      sc_q    <= 5'd0;
      pipe_q  <= 1'b0;
      steal_q <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      pipe_q  <= pipe_d;
      steal_q <= steal_d;
    end
  end

  assign phase       = sc_q[1:0];
  assign ce12        = sc_q[0];
  assign ce6         = (sc_q[1:0] == PH_ACK);
  assign cpu_slot    = sc_q[2] | steal_d;
  assign video_slice = ~cpu_slot;
  assign pipe_ab     = pipe_d;

endmodule

// File: rtl/sram_slot_arbiter.sv
// rtl/sram_slot_arbiter.sv - shares one 8-bit SRAM between video fetch slots and a req/ack CPU port
// Optional VIDEO_STEAL_EN (in slot_timer) lets blanked video slots serve the CPU.
module sram_slot_arbiter
  import sram_slot_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk24,
  input  logic              reset,
  output logic              ce12,
  output logic              ce6,
  output logic              video_slice,
  output logic              pipe_ab,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_blank,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_dq_in,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  logic [1:0] phase;
  logic       cpu_slot;

  slot_timer u_timer (
    .clk24       (clk24),
    .reset       (reset),
    .vid_blank   (vid_blank),
    .phase       (phase),
    .ce12        (ce12),
    .ce6         (ce6),
    .video_slice (video_slice),
    .pipe_ab     (pipe_ab),
    .cpu_slot    (cpu_slot)
  );

  cpu_state_e        state_q, state_d, st;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;

  always_comb begin
    // ADDR is entered combinationally so the access owns phase 0 of its slot.
    st = state_q;
    if (state_q == ST_IDLE && cpu_slot && phase == PH_ADDR && cpu_req) st = ST_ADDR;
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (st)
      ST_ADDR: begin
        state_d = ST_STROBE;
        we_d    = cpu_we;
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
      end
      ST_STROBE: state_d = ST_DATA;
      ST_DATA: begin
        state_d = ST_ACK;
        if (!we_q) rdata_d = sram_dq_in;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_addr   = (st != ST_IDLE) ? addr_d : vid_addr;
  assign sram_dq_out = wdata_d;
  assign sram_dq_oe  = (st != ST_IDLE) & we_d;
  assign sram_we_n   = ~(we_q & (st == ST_STROBE || st == ST_DATA));
  assign cpu_ack     = (st == ST_ACK);
  assign cpu_rdata   = rdata_q;

endmodule

// File: doc/sram_slot_arbiter.md
Name: sram_slot_arbiter

Overview:
- Shares the single 8-bit video/system SRAM between the framebuffer fetch path and the CPU bus.
- Owns the master clk24 time base: produces ce12, ce6, video_slice and pipe_ab for the video subsystem.
- Time-multiplexes SRAM address, data and strobes between a fixed video fetch schedule and a req/ack CPU port.
- Sits between the CPU bus interface, the video subsystem and the SRAM pins at top level.

Parameters:
- SLOT_LEN, 4, clk24 cycles per slot; fixed at 4; other values unsupported.
- ADDR_W, 16, SRAM address width.

Ports:
- clk24  in  1  master clock, 24 MHz.
- reset  in  1  asynchronous, active-high reset.
- ce12  out  1  clock enable, 12 MHz.
- ce6  out  1  clock enable, 6 MHz.
- video_slice  out  1  current slot belongs to video fetch.
- pipe_ab  out  1  video plane-pair select for the framebuffer register pipeline.
- vid_addr  in  16  video fetch address from the framebuffer.
- vid_blank  in  1  video outside the active area; used only with the optional feature.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid with cpu_ack, held until the next ack.
- sram_addr  out  16  SRAM address.
- sram_dq_in  in  8  SRAM data in.
- sram_dq_out  out  8  SRAM write data.
- sram_dq_oe  out  1  drive the SRAM data bus.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- 5-bit free-running counter sc, +1 every clk24, wraps 31→0.
  - slot = sc[4:2]; phase = sc[1:0].
- ce12 = (sc[0]==1). ce6 = (phase==3). Both are combinational decodes of registered sc.
- Even slots (sc[2]==0) are video slots:
  - video_slice = 1.
  - sram_addr = vid_addr.
  - pipe_ab = sc[3].
- Odd slots are CPU slots.
  - video_slice = 0 and pipe_ab holds its last value.
  - sram_addr = latched CPU address, or vid_addr when the slot is idle.
- CPU FSM, advanced on slot phase: IDLE → ADDR → STROBE → DATA → ACK → IDLE.
  - IDLE→ADDR only at phase 0 of a CPU slot with cpu_req=1. Latch cpu_addr, cpu_we and cpu_wdata at this point.
  - ADDR (phase 0): sram_dq_oe = we_latched.
  - STROBE (phase 1) and DATA (phase 2): sram_we_n = ~we_latched.
  - DATA (phase 2), read: cpu_rdata <= sram_dq_in, registered at the end of phase 2.
  - ACK (phase 3): cpu_ack = 1 for one cycle; sram_we_n = 1; sram_dq_oe stays on through phase 3 for writes.
- sram_we_n is never low outside phases 1–2 of a CPU write slot. sram_dq_oe is never high in a video slot.
- Request latency:
  - cpu_req first seen at phase 0 of a CPU slot: ack 3 cycles later.
  - Worst case (req raised one cycle after a CPU slot's phase 0): ack 10 cycles after req.
- Back-to-back: with cpu_req still high after ack, the next request is served in the next CPU slot, 8 cycles after the previous ADDR.
- cpu_req dropped mid-transaction is a protocol violation. The access still completes, the write is performed and ack is issued.
- Async reset, also mid-access:
  - sc=0, FSM=IDLE, cpu_ack=0, cpu_rdata=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, pipe_ab=0.
  - The pending CPU access is dropped without ack.
  - The first cycle after reset release is slot 0 / phase 0 (video).

Optional Feature:
- Macro: VIDEO_STEAL_EN.
- Defined:
  - vid_blank is sampled at phase 0 of each video slot.
  - If 1, that slot is run as a CPU slot using identical FSM timing, with video_slice=0 for its 4 cycles. pipe_ab still follows sc[3].
  - The decision holds for the whole slot, even if vid_blank changes mid-slot.
- Undefined: vid_blank is ignored and the schedule is fixed 50/50.

Decomposition:
- Package sram_slot_pkg:
  - SLOT_LEN.
  - Phase constants PH_ADDR=0, PH_STROBE=1, PH_DATA=2, PH_ACK=3.
  - CPU FSM state encoding.
- Sub-module slot_timer: sc counter plus ce12/ce6/video_slice/pipe_ab decode. The arbiter FSM and SRAM muxing stay in the top.

Test Plan:
- Reset release, no cpu_req, 64 cycles:
  - ce12 period 2, ce6 high at sc=3,7,…
  - video_slice high at sc 0–3, 8–11, 16–19, 24–27.
  - pipe_ab = sc[3]; sram_we_n constantly 1.
- Write: cpu_req=1, we=1, addr=16'h1234, wdata=8'hA5, asserted at sc=3:
  - sram_addr=16'h1234 at sc=4..7.
  - sram_we_n low at sc=5,6; dq_out=A5 with oe at sc=4..7.
  - cpu_ack at sc=7.
- Read: addr=16'h00FF with the SRAM model returning 8'h3C, req at sc=5:
  - Served at sc=12..15; cpu_ack at sc=15; cpu_rdata=3C.
  - rdata held until the next ack.
- Reset pulse at sc=13 during a write:
  - All outputs go to reset values immediately; no ack is issued.
  - After release, sc=0 and video_slice=1.
- Continuous cpu_req for 3 accesses: acks at sc=7, 15, 23; video slots untouched.
- With VIDEO_STEAL_EN and vid_blank=1: cpu_ack every 4 cycles (sc=3, 7, 11, …) and video_slice stays 0. Without the macro, acks come every 8 cycles.
